// File: rtl/uart_rx_core.sv
// 8N1 UART receive engine: 2-flop line synchroniser, mid-bit sampling with a
// programmable clocks-per-bit divisor, and a one-entry valid/ready holding register.
module uart_rx_core #(
  parameter int DIV_W     = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_i,
  input  logic [DIV_W-1:0]     baud_div_i,
  input  logic                 rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  input  logic                 err_clr_i,
  output logic                 busy_o
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;
  logic [DIV_W-1:0]     n_q;
  logic [DIV_W-1:0]     n_sel;
  logic [DIV_W-1:0]     half_m1;
  logic [DIV_W-1:0]     full_m1;
  logic [DIV_W-1:0]     cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 fall;
  logic                 accept;

  // Handshake: a byte is transferred on every rising edge where
  // rx_valid_o & rx_ready_i; rx_valid_o holds steady until then.
  assign n_sel   = (baud_div_i < DIV_W'(2)) ? DIV_W'(2) : baud_div_i;
  assign half_m1 = (n_q >> 1) - DIV_W'(1);
  assign full_m1 = n_q - DIV_W'(1);
  assign fall    = rx_prev & ~rx_s;
  assign accept  = rx_valid_o & rx_ready_i;
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      n_q         <= DIV_W'(2);
      cnt         <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      rx_data_o   <= '0;
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;

      if (accept) rx_valid_o <= 1'b0;
      // Set events below are assigned later, so they win over a same-cycle clear.
      if (err_clr_i) begin
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end

      if (!en_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              cnt   <= '0;
              n_q   <= n_sel;
              state <= START;
            end
          end
          START: begin
            if (cnt == half_m1) begin
              cnt     <= '0;
              bit_idx <= '0;
              state   <= rx_s ? IDLE : DATA;
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          DATA: begin
            if (cnt == full_m1) begin
              cnt              <= '0;
              shift_q[bit_idx] <= rx_s;
              if (bit_idx == IDX_W'(DATA_BITS - 1)) state <= STOP;
              else bit_idx <= bit_idx + IDX_W'(1);
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          STOP: begin
            if (cnt == full_m1) begin
              cnt   <= '0;
              state <= IDLE;
              // A byte accepted on this same edge frees the holding register.
              if (!rx_s) begin
                frame_err_o <= 1'b1;
              end else if (!rx_valid_o || rx_ready_i) begin
                rx_data_o  <= shift_q;
                rx_valid_o <= 1'b1;
              end else begin
                overrun_o <= 1'b1;
              end
            end else begin
              cnt <= cnt + DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frame table, hand-built corner
// sequences, then random frames against a frame-level holding-register model.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_i = 1'b0;
  logic [15:0] baud_div_i = 16'd16;
  logic       rx_i = 1'b1;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i = 1'b0;
  logic       frame_err_o;
  logic       overrun_o;
  logic       err_clr_i = 1'b0;
  logic       busy_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];
  logic       m_ferr;
  logic       m_ovr;

  typedef struct {
    int         div;
    logic [7:0] data;
    logic       stop;
    logic       drain;
    logic       clr;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[9];

  uart_rx_core #(.DIV_W(16), .DATA_BITS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en_i),
    .baud_div_i  (baud_div_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .err_clr_i   (err_clr_i),
    .busy_o      (busy_o)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives start, data (LSB first) and stop bits from a negedge; cut>0 aborts
  // the frame after that many bit-time cycles and returns the line to idle.
  task automatic drive_frame(input int div, input logic [7:0] data, input logic stop,
                             input int cut);
    int p;
    logic [9:0] wave;
    p = (div < 2) ? 2 : div;
    wave = {stop, data, 1'b0};
    baud_div_i = 16'(div);
    for (int c = 0; c < 10 * p; c++) begin
      if (cut != 0 && c == cut) break;
      rx_i = wave[c / p];
      @(negedge clk);
    end
    rx_i = 1'b1;
  endtask

  task automatic pulse_ready();
    rx_ready_i = 1'b1;
    @(negedge clk);
    rx_ready_i = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
  endtask

  task automatic idle_wait(input int div);
    repeat (((div < 2) ? 2 : div) + 6) @(negedge clk);
  endtask

  initial begin
    int lat;
    int div;
    logic [7:0] data;
    logic stop;

    vecs[0] = '{16, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{16, 8'h7E, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
    vecs[2] = '{16, 8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
    vecs[3] = '{16, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    vecs[4] = '{ 1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[5] = '{ 0, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[6] = '{ 5, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0};
    vecs[7] = '{ 3, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 1'b1, 1'b1};
    vecs[8] = '{ 7, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data", rx_data_o, 0);
    check("rst_valid", rx_valid_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    check("rst_busy", busy_o, 0);
    en_i = 1'b1;
    @(negedge clk);

    // 0xA5 at 16 clk/bit with latency measurement
    lat = 0;
    fork
      drive_frame(16, 8'hA5, 1'b1, 0);
      begin
        for (int k = 1; k <= 400; k++) begin
          @(negedge clk);
          if (rx_valid_o === 1'b1) begin
            lat = k;
            break;
          end
        end
      end
    join
    n_cmp++;
    if (lat < 153 || lat > 156) begin
      n_err++;
      $display("FAIL a5_latency: got %0d cycles expected 153..156", lat);
    end
    check("a5_data", rx_data_o, 8'hA5);
    check("a5_ferr", frame_err_o, 0);
    check("a5_ovr", overrun_o, 0);
    pulse_ready();
    check("a5_drained", rx_valid_o, 0);

    // Short low glitch is a false start
    rx_i = 1'b0;
    repeat (4) @(negedge clk);
    rx_i = 1'b1;
    repeat (16) @(negedge clk);
    check("glitch_valid", rx_valid_o, 0);
    check("glitch_ferr", frame_err_o, 0);
    check("glitch_busy", busy_o, 0);

    // Directed frame table
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].drain) pulse_ready();
      if (vecs[i].clr) pulse_clr();
      drive_frame(vecs[i].div, vecs[i].data, vecs[i].stop, 0);
      idle_wait(vecs[i].div);
      check($sformatf("vec%0d_valid", i), rx_valid_o, vecs[i].exp_valid);
      if (vecs[i].exp_valid) check($sformatf("vec%0d_data", i), rx_data_o, vecs[i].exp_data);
      check($sformatf("vec%0d_ferr", i), frame_err_o, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), overrun_o, vecs[i].exp_ovr);
      check($sformatf("vec%0d_busy", i), busy_o, 0);
    end

    // Back-to-back frames, consumer stalled
    pulse_ready();
    pulse_clr();
    drive_frame(16, 8'h11, 1'b1, 0);
    drive_frame(16, 8'h22, 1'b1, 0);
    idle_wait(16);
    check("b2b_valid", rx_valid_o, 1);
    check("b2b_data", rx_data_o, 8'h11);
    check("b2b_ovr", overrun_o, 1);

    // Back-to-back with accept on the second frame's stop-sample edge
    pulse_ready();
    pulse_clr();
    drive_frame(16, 8'h11, 1'b1, 0);
    fork
      drive_frame(16, 8'h22, 1'b1, 0);
      begin
        repeat (154) @(negedge clk);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
      end
    join
    idle_wait(16);
    check("acc_stop_valid", rx_valid_o, 1);
    check("acc_stop_data", rx_data_o, 8'h22);
    check("acc_stop_ovr", overrun_o, 0);

    // Reset mid-frame with a byte pending and a sticky flag set
    drive_frame(16, 8'h3C, 1'b0, 0);
    idle_wait(16);
    check("pre_rst_ferr", frame_err_o, 1);
    drive_frame(16, 8'h99, 1'b1, 88);
    check("pre_rst_busy", busy_o, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_data", rx_data_o, 0);
    check("midrst_valid", rx_valid_o, 0);
    check("midrst_ferr", frame_err_o, 0);
    check("midrst_ovr", overrun_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    drive_frame(16, 8'h5A, 1'b1, 0);
    idle_wait(16);
    check("post_rst_valid", rx_valid_o, 1);
    check("post_rst_data", rx_data_o, 8'h5A);

    // Enable dropped mid-frame
    pulse_ready();
    drive_frame(16, 8'h33, 1'b1, 70);
    check("en_drop_busy_before", busy_o, 1);
    en_i = 1'b0;
    @(negedge clk);
    check("en_drop_busy_after", busy_o, 0);
    repeat (200) @(negedge clk);
    en_i = 1'b1;
    @(negedge clk);
    check("en_drop_valid", rx_valid_o, 0);
    check("en_drop_ferr", frame_err_o, 0);
    check("en_drop_ovr", overrun_o, 0);

    // Random frames against the frame-level model
    exp_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int f = 0; f < 30; f++) begin
      div  = $urandom_range(0, 20);
      data = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 1) == 1 && exp_q.size() > 0) begin
        pulse_ready();
        void'(exp_q.pop_front());
      end
      if ($urandom_range(0, 3) == 0) begin
        pulse_clr();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      drive_frame(div, data, stop, 0);
      idle_wait(div);
      if (!stop) m_ferr = 1'b1;
      else if (exp_q.size() == 0) exp_q.push_back(data);
      else m_ovr = 1'b1;
      check($sformatf("rnd%0d_valid", f), rx_valid_o, (exp_q.size() != 0));
      if (exp_q.size() != 0) check($sformatf("rnd%0d_data", f), rx_data_o, exp_q[0]);
      check($sformatf("rnd%0d_ferr", f), frame_err_o, m_ferr);
      check($sformatf("rnd%0d_ovr", f), overrun_o, m_ovr);
      check($sformatf("rnd%0d_busy", f), busy_o, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
